if_id_stage_reg: RTL and testbench

//  IF/ID pipeline register of the 16-bit CPU. Captures the incremented PC and
//  the fetched instruction every clock and presents them to decode.
//  - nop: inserts a bubble and rewinds the PC so the same instruction is re-fetched.
//  - flush: kills the fetched instruction (branch/jump redirect).

---
 rtl/if_id_stage_reg.sv | 51 +++++
 tb/tb_if_id_stage_reg.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register: registers the incremented PC and fetched instruction for decode.
// Optional feature macro IF_ID_VALID_EN adds a registered valid_out flag.
module if_id_stage_reg #(
    parameter int unsigned    DATA_W    = 16,
    parameter int unsigned    PC_STEP   = 2,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] inc_PC_in,
    input  logic [DATA_W-1:0] instr_in,
    input  logic              nop,
    input  logic              flush,
    output logic [DATA_W-1:0] PC_out,
    output logic [DATA_W-1:0] instr_out
`ifdef IF_ID_VALID_EN
    ,
    output logic              valid_out
`endif
);

    localparam logic [DATA_W-1:0] STEP = DATA_W'(PC_STEP);

    // Flush outranks nop: the redirect target must not be rewound.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            PC_out    <= '0;
            instr_out <= NOP_INSTR;
        end else if (flush) begin
            PC_out    <= inc_PC_in;
            instr_out <= NOP_INSTR;
        end else if (nop) begin
            PC_out    <= inc_PC_in - STEP;
            instr_out <= NOP_INSTR;
        end else begin
            PC_out    <= inc_PC_in;
            instr_out <= instr_in;
        end
    end

`ifdef IF_ID_VALID_EN
    always_ff @(posedge clk) begin
        if (!rst_n || flush || nop) begin
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Scoreboard bench for if_id_stage_reg: stimulus pushes modelled results, a monitor pops and compares.
module tb_if_id_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] inc_PC_in = '0;
    logic [15:0] instr_in = '0;
    logic        nop = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] PC_out;
    logic [15:0] instr_out;
`ifdef IF_ID_VALID_EN
    logic        valid_out;
`endif

    if_id_stage_reg #(
        .DATA_W   (16),
        .PC_STEP  (2),
        .NOP_INSTR(16'h0000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_PC_in(inc_PC_in),
        .instr_in (instr_in),
        .nop      (nop),
        .flush    (flush),
        .PC_out   (PC_out),
        .instr_out(instr_out)
`ifdef IF_ID_VALID_EN
        ,
        .valid_out(valid_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned pc;
        int unsigned ins;
        bit          v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference: the stage's rules written as plain arithmetic on integers.
    function automatic exp_t model(bit r, int unsigned inc, int unsigned ins,
                                   bit n, bit f, string name);
        exp_t e;
        e.name = name;
        if (!r) begin
            e.pc = 0; e.ins = 0; e.v = 0;
        end else if (f) begin
            e.pc = inc; e.ins = 0; e.v = 0;
        end else if (n) begin
            e.pc = (inc + 65536 - 2) % 65536; e.ins = 0; e.v = 0;
        end else begin
            e.pc = inc; e.ins = ins; e.v = 1;
        end
        return e;
    endfunction

    task automatic step(input bit r, input int unsigned inc, input int unsigned ins,
                        input bit n, input bit f, input string name);
        @(negedge clk);
        rst_n     = r;
        inc_PC_in = 16'(inc);
        instr_in  = 16'(ins);
        nop       = n;
        flush     = f;
        exp_q.push_back(model(r, inc, ins, n, f, name));
    endtask

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Monitor: every edge retires one outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".pc"}, int'(PC_out), e.pc);
            check({e.name, ".instr"}, int'(instr_out), e.ins);
`ifdef IF_ID_VALID_EN
            check({e.name, ".valid"}, int'(valid_out), int'(e.v));
`endif
        end
    end

    initial begin
        int unsigned inc, ins, sel;
        bit r, n, f;

        step(1'b0, 16'h0202, 16'h0202, 1'b1, 1'b1, "reset");
        step(1'b1, 16'h0202, 16'h0202, 1'b0, 1'b0, "normal");
        step(1'b1, 16'h0202, 16'h0202, 1'b1, 1'b0, "nop");
        step(1'b1, 16'h0202, 16'h0202, 1'b0, 1'b1, "flush");
        step(1'b1, 16'h1234, 16'hBEEF, 1'b1, 1'b1, "nop_flush");
        step(1'b1, 16'h0001, 16'h5555, 1'b1, 1'b0, "wrap1");
        step(1'b1, 16'h0000, 16'h5555, 1'b1, 1'b0, "wrap0");
        step(1'b1, 16'h0000, 16'h5555, 1'b1, 1'b0, "nop_repeat");
        step(1'b0, 16'hAAAA, 16'h7777, 1'b0, 1'b0, "reset_mid");
        step(1'b1, 16'hAAAA, 16'h7777, 1'b0, 1'b0, "after_reset");

        for (int i = 2; i <= 254; i++) begin
            inc = (i << 8) | i;
            step(1'b1, inc, inc, 1'b0, 1'b0, "sweep_normal");
            step(1'b1, inc, inc, 1'b1, 1'b0, "sweep_nop");
            step(1'b1, inc, inc, 1'b0, 1'b1, "sweep_flush");
        end

        for (int i = 0; i < 400; i++) begin
            inc = $urandom_range(0, 65535);
            ins = $urandom_range(0, 65535);
            sel = $urandom_range(0, 15);
            r = (sel != 0);
            n = $urandom_range(0, 2) == 0;
            f = $urandom_range(0, 3) == 0;
            step(r, inc, ins, n, f, "random");
        end

        @(negedge clk);
        rst_n = 1'b1; nop = 1'b0; flush = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
